// File: rtl/key_input_ctrl_pkg.sv
// Shared constants and types for the front-panel key input block.
// Button indices, default timing, handshake state encoding.
package key_input_ctrl_pkg;

   localparam int BTN_CONFIRM = 0;
   localparam int BTN_BACK    = 1;
   localparam int BTN_UP      = 2;
   localparam int BTN_DOWN    = 3;
   localparam int BTN_CENTER  = 4;

   localparam int DEF_DB_CYCLES     = 2_000_000;
   localparam int DEF_HOLD_CYCLES   = 50_000_000;
   localparam int DEF_REPEAT_CYCLES = 10_000_000;

   typedef enum logic {
      HS_IDLE = 1'b0,
      HS_PEND = 1'b1
   } hs_state_t;

   // bits needed to hold the values 0 .. n-1
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_input_ctrl_btn.sv
// One push-button: 2-FF synchroniser, debounce, press pulse
// and optional auto-repeat while the debounced level stays high.
module btn_debounce
   import key_input_ctrl_pkg::*;
#(
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit REPEAT_EN     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);

   localparam int DW   = cnt_w(DB_CYCLES);
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                         HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW   = cnt_w(HMAX);

   localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          db_state;
   logic          db_prev;
   logic          rpt;
   logic [DW-1:0] cnt;
   logic [HW-1:0] hold_cnt;
   logic          rise;
   logic          held;
   logic          hold_hit;

   assign btn_level = db_state;
   assign rise      = db_state & ~db_prev;
   assign held      = db_state & db_prev;
   assign hold_hit  = REPEAT_EN && held &&
                      (hold_cnt == (rpt ? RPT_LAST : HOLD_LAST));

   // bring the asynchronous button into the clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // accept a new level only after DB_CYCLES mismatched samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         db_state <= 1'b0;
      end else if (sync2 == db_state) begin
         cnt <= '0;
      end else if (cnt == DB_LAST) begin
         cnt      <= '0;
         db_state <= sync2;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // hold timer: initial delay, then the repeat period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         rpt      <= 1'b0;
      end else if (!held) begin
         hold_cnt <= '0;
         rpt      <= 1'b0;
      end else if (hold_hit) begin
         hold_cnt <= '0;
         rpt      <= 1'b1;
      end else if (REPEAT_EN) begin
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

   // press edge detect and registered pulse output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_prev   <= 1'b0;
         btn_pulse <= 1'b0;
      end else begin
         db_prev   <= db_state;
         btn_pulse <= rise | hold_hit;
      end
   end

endmodule

// File: rtl/key_input_ctrl.sv
// Front-panel input side: debounced buttons with repeat, and
// CONFIRM-triggered operand capture offered over valid/ready.
module key_input_ctrl
   import key_input_ctrl_pkg::*;
#(
   parameter int NUM_BTN       = 5,
   parameter int SW_W          = 8,
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK = NUM_BTN'(5'b01100),
   parameter int CONFIRM_IDX   = BTN_CONFIRM
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic [SW_W-1:0]    sw_raw,
   input  logic [SW_W-1:0]    val_max,
   input  logic               data_ready,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse,
   output logic [SW_W-1:0]    data_out,
   output logic               data_valid,
   output logic               input_err,
   output logic               overrun
);

   hs_state_t       state;
   hs_state_t       state_nxt;
   logic [SW_W-1:0] sw_s1;
   logic [SW_W-1:0] sw_s2;
   logic            confirm;
   logic            sw_ok;
   logic            in_pend;
   logic            xfer;
   logic            load;
   logic            err_nxt;
   logic            ovr_set;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(
         .DB_CYCLES     (DB_CYCLES),
         .HOLD_CYCLES   (HOLD_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .REPEAT_EN     (REPEAT_MASK[i] && (i != CONFIRM_IDX))
      ) u_db (
         .clk       (clk),
         .rst       (rst),
         .btn_raw   (btn_raw[i]),
         .btn_level (btn_level[i]),
         .btn_pulse (btn_pulse[i])
      );
   end

   assign confirm = btn_pulse[CONFIRM_IDX];
   assign sw_ok   = (sw_s2 <= val_max);

   // switches are only synchronised; they are sampled on CONFIRM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= sw_raw;
         sw_s2 <= sw_s1;
      end
   end

   // handshake state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= HS_IDLE;
      else     state <= state_nxt;
   end

   // next state: a legal CONFIRM keeps or enters PEND
   always_comb begin
      state_nxt = state;
      unique case (state)
         HS_IDLE: if (confirm && sw_ok) state_nxt = HS_PEND;
         HS_PEND: if (data_ready && !(confirm && sw_ok))
                     state_nxt = HS_IDLE;
      endcase
   end

   // decode capture, error and overrun conditions
   always_comb begin
      in_pend    = (state == HS_PEND);
      data_valid = in_pend;
      xfer       = in_pend & data_ready;
      load       = confirm & sw_ok & (~in_pend | data_ready);
      err_nxt    = confirm & ~sw_ok;
      ovr_set    = confirm & in_pend & ~data_ready;
   end

   // operand, error pulse and sticky overrun flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         input_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) data_out <= sw_s2;
         input_err <= err_nxt;
         if (ovr_set)   overrun <= 1'b1;
         else if (xfer) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with short debounce timing.
// Table-driven handshake vectors plus hand-written timing sequences.
module tb_key_input_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn_raw = '0;
   logic [7:0] sw_raw = '0;
   logic [7:0] val_max = 8'h09;
   logic       data_ready = 1'b0;
   logic [4:0] btn_level;
   logic [4:0] btn_pulse;
   logic [7:0] data_out;
   logic       data_valid;
   logic       input_err;
   logic       overrun;

   int n_chk = 0;
   int n_pass = 0;
   int ecnt = 0;
   int pcnt = 0;
   int plast = -1;
   int widx = 0;
   int pedges[$];

   typedef struct {
      logic [4:0] btn;
      logic [7:0] sw;
      logic       rdy;
      int         n;
      logic [4:0] lvl;
      logic [4:0] pls;
      logic [7:0] dout;
      logic       vld;
      logic       err;
      logic       ovr;
   } vec_t;

   vec_t vt[$];

   key_input_ctrl #(
      .DB_CYCLES     (4),
      .HOLD_CYCLES   (20),
      .REPEAT_CYCLES (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_raw    (btn_raw),
      .sw_raw     (sw_raw),
      .val_max    (val_max),
      .data_ready (data_ready),
      .btn_level  (btn_level),
      .btn_pulse  (btn_pulse),
      .data_out   (data_out),
      .data_valid (data_valid),
      .input_err  (input_err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      ecnt++;
      if (btn_pulse[widx]) begin
         pcnt++;
         plast = ecnt;
         pedges.push_back(ecnt);
      end
   endtask

   function automatic void add(logic [4:0] b, logic [7:0] s, logic r,
                               int n, logic [4:0] l, logic [4:0] p,
                               logic [7:0] d, logic v, logic e, logic o);
      vec_t x;
      x.btn = b; x.sw = s; x.rdy = r; x.n = n;
      x.lvl = l; x.pls = p; x.dout = d;
      x.vld = v; x.err = e; x.ovr = o;
      vt.push_back(x);
   endfunction

   initial begin
      int rep_exp[5];
      rep_exp = '{6, 26, 31, 36, 41};

      //   btn       sw     rdy n  lvl       pls       dout   v  e  o
      add(5'b00000, 8'h05, 0, 3, 5'b00000, 5'b00000, 8'h00, 0, 0, 0);
      add(5'b00100, 8'h05, 0, 5, 5'b00000, 5'b00000, 8'h00, 0, 0, 0);
      add(5'b00100, 8'h05, 0, 1, 5'b00100, 5'b00000, 8'h00, 0, 0, 0);
      add(5'b00100, 8'h05, 0, 1, 5'b00100, 5'b00100, 8'h00, 0, 0, 0);
      add(5'b00100, 8'h05, 0, 1, 5'b00100, 5'b00000, 8'h00, 0, 0, 0);
      add(5'b00000, 8'h05, 0, 5, 5'b00100, 5'b00000, 8'h00, 0, 0, 0);
      add(5'b00000, 8'h05, 0, 1, 5'b00000, 5'b00000, 8'h00, 0, 0, 0);
      add(5'b00001, 8'h05, 0, 7, 5'b00001, 5'b00001, 8'h00, 0, 0, 0);
      add(5'b00001, 8'h05, 0, 1, 5'b00001, 5'b00000, 8'h05, 1, 0, 0);
      add(5'b00000, 8'h05, 0, 8, 5'b00000, 5'b00000, 8'h05, 1, 0, 0);
      add(5'b00001, 8'h03, 0, 7, 5'b00001, 5'b00001, 8'h05, 1, 0, 0);
      add(5'b00001, 8'h03, 0, 1, 5'b00001, 5'b00000, 8'h05, 1, 0, 1);
      add(5'b00000, 8'h03, 0, 8, 5'b00000, 5'b00000, 8'h05, 1, 0, 1);
      add(5'b00000, 8'h03, 1, 1, 5'b00000, 5'b00000, 8'h05, 0, 0, 0);
      add(5'b00000, 8'h03, 0, 2, 5'b00000, 5'b00000, 8'h05, 0, 0, 0);
      add(5'b00001, 8'h0C, 0, 7, 5'b00001, 5'b00001, 8'h05, 0, 0, 0);
      add(5'b00001, 8'h0C, 0, 1, 5'b00001, 5'b00000, 8'h05, 0, 1, 0);
      add(5'b00001, 8'h0C, 0, 1, 5'b00001, 5'b00000, 8'h05, 0, 0, 0);
      add(5'b00000, 8'h0C, 0, 8, 5'b00000, 5'b00000, 8'h05, 0, 0, 0);
      add(5'b00001, 8'h07, 0, 7, 5'b00001, 5'b00001, 8'h05, 0, 0, 0);
      add(5'b00001, 8'h07, 0, 1, 5'b00001, 5'b00000, 8'h07, 1, 0, 0);
      add(5'b00000, 8'h07, 0, 8, 5'b00000, 5'b00000, 8'h07, 1, 0, 0);
      add(5'b00001, 8'h02, 0, 7, 5'b00001, 5'b00001, 8'h07, 1, 0, 0);
      add(5'b00001, 8'h02, 1, 1, 5'b00001, 5'b00000, 8'h02, 1, 0, 0);
      add(5'b00000, 8'h02, 0, 8, 5'b00000, 5'b00000, 8'h02, 1, 0, 0);
      add(5'b00001, 8'h0F, 0, 7, 5'b00001, 5'b00001, 8'h02, 1, 0, 0);
      add(5'b00001, 8'h0F, 1, 1, 5'b00001, 5'b00000, 8'h02, 0, 1, 0);
      add(5'b00000, 8'h0F, 0, 8, 5'b00000, 5'b00000, 8'h02, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vt[k]) begin
         btn_raw    = vt[k].btn;
         sw_raw     = vt[k].sw;
         data_ready = vt[k].rdy;
         repeat (vt[k].n) tick();
         chk($sformatf("r%0d_level", k), 32'(btn_level), 32'(vt[k].lvl));
         chk($sformatf("r%0d_pulse", k), 32'(btn_pulse), 32'(vt[k].pls));
         chk($sformatf("r%0d_dout", k), 32'(data_out), 32'(vt[k].dout));
         chk($sformatf("r%0d_valid", k), 32'(data_valid), 32'(vt[k].vld));
         chk($sformatf("r%0d_err", k), 32'(input_err), 32'(vt[k].err));
         chk($sformatf("r%0d_ovr", k), 32'(overrun), 32'(vt[k].ovr));
      end
      data_ready = 1'b0;

      // bounce 1,0,1 on BACK then hold
      widx = 1; pcnt = 0; plast = -1; ecnt = -1; pedges.delete();
      btn_raw = 5'b00010; tick(); tick();
      btn_raw = 5'b00000; tick(); tick();
      btn_raw = 5'b00010;
      repeat (12) tick();
      chk("bounce_count", 32'(pcnt), 32'd1);
      chk("bounce_edge", 32'(plast), 32'd10);
      chk("bounce_level", 32'(btn_level), 32'b00010);
      btn_raw = '0;
      repeat (8) tick();

      // hold UP for 40 cycles: press, then auto-repeat
      widx = 2; pcnt = 0; plast = -1; ecnt = -1; pedges.delete();
      btn_raw = 5'b00100;
      repeat (40) tick();
      btn_raw = '0;
      repeat (30) tick();
      chk("repeat_count", 32'(pcnt), 32'd5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("repeat_edge%0d", i),
             32'((i < pedges.size()) ? pedges[i] : -1), 32'(rep_exp[i]));

      // reset mid-debounce with another button stable high
      btn_raw = 5'b01000;
      repeat (8) tick();
      chk("pre_rst_level", 32'(btn_level), 32'b01000);
      btn_raw = 5'b11000;
      repeat (2) tick();
      rst = 1'b1;
      #1;
      chk("rst_async_level", 32'(btn_level), 32'd0);
      chk("rst_async_pulse", 32'(btn_pulse), 32'd0);
      btn_raw = '0;
      repeat (2) tick();
      rst = 1'b0;
      widx = 4; pcnt = 0;
      repeat (20) tick();
      chk("rst_no_pulse", 32'(pcnt), 32'd0);
      chk("rst_level_idle", 32'(btn_level), 32'd0);

      // button held through reset release gives a normal press
      rst = 1'b1;
      btn_raw = 5'b10000;
      tick(); tick();
      rst = 1'b0;
      widx = 4; pcnt = 0; plast = -1; ecnt = -1;
      repeat (12) tick();
      chk("held_rst_count", 32'(pcnt), 32'd1);
      chk("held_rst_edge", 32'(plast), 32'd6);
      btn_raw = '0;
      repeat (8) tick();

      // reset while an operand is pending
      sw_raw = 8'h04;
      btn_raw = 5'b00001;
      repeat (8) tick();
      chk("pend_valid", 32'(data_valid), 32'd1);
      chk("pend_dout", 32'(data_out), 32'h04);
      btn_raw = '0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      chk("pend_rst_valid", 32'(data_valid), 32'd0);
      chk("pend_rst_dout", 32'(data_out), 32'd0);
      chk("pend_rst_ovr", 32'(overrun), 32'd0);
      chk("pend_rst_level", 32'(btn_level), 32'd0);
      tick();
      rst = 1'b0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
